// File: rtl/instruction_memory_loader_pkg.sv
// Shared constants and loader state encoding for the instruction memory loader.
// Imported by the top and the byte/word assembler.
package instruction_memory_loader_pkg;

    localparam int NB             = 32;
    localparam int NB_BYTE        = 8;
    localparam int BYTES_PER_WORD = NB / NB_BYTE;

    localparam logic [NB-1:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [NB-1:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_LOADING = 2'd1,
        LD_DONE    = 2'd2
    } ld_state_t;

endpackage

// File: rtl/instruction_memory_loader_byte_word_assembler.sv
// Packs loader bytes MSB-first into words; o_word_valid pulses with the 4th byte of a word.
// o_word is combinational so the word can be written on the same edge that accepts its last byte.
module instruction_memory_loader_byte_word_assembler
    import instruction_memory_loader_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_shift,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [NB-1:0]      o_word,
    output logic               o_word_valid
);

    localparam int NB_HELD = NB - NB_BYTE;

    // Only the first three bytes need storage; the fourth arrives on i_byte.
    logic [NB_HELD-1:0] word_q;
    logic [1:0]         byte_cnt;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            word_q   <= '0;
            byte_cnt <= '0;
        end else if (i_start) begin
            // A byte arriving with start is byte 0 of the new program.
            word_q   <= i_shift ? NB_HELD'(i_byte) : '0;
            byte_cnt <= i_shift ? 2'd1 : 2'd0;
        end else if (i_shift) begin
            word_q   <= {word_q[NB_HELD-NB_BYTE-1:0], i_byte};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign o_word       = {word_q, i_byte};
    assign o_word_valid = i_shift && !i_start && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_memory_loader.sv
// Fetch-stage instruction memory: debug unit streams a program in byte by byte,
// then the pipeline reads words by PC byte address with one cycle of latency.
module instruction_memory_loader
    import instruction_memory_loader_pkg::*;
#(
    parameter int N_WORDS = 64,
    parameter int NB_ADDR = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NB-1:0]      i_pc,
    input  logic               i_load_start,
    input  logic               i_load_valid,
    input  logic [NB_BYTE-1:0] i_load_byte,
    output logic [NB-1:0]      o_instruction,
    output logic               o_load_done,
    output logic [NB_ADDR:0]   o_load_count,
    output logic               o_halt_fetched,
    output logic [1:0]         o_dbg_state
);

    ld_state_t state, next_state;

    logic [NB_ADDR:0]   wr_ptr;
    logic [NB-1:0]      mem [N_WORDS];
    logic [NB-1:0]      asm_word;
    logic               asm_word_valid;
    logic               shift_en;
    logic               fetch;
    logic [NB-1:0]      rd_word;
    logic               last_word;
    logic               unused_pc_byte_sel;

    // Bytes are accepted only while loading, or alongside a start pulse.
    assign shift_en = i_load_valid && (i_load_start || (state == LD_LOADING));

    instruction_memory_loader_byte_word_assembler u_assembler (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_start      (i_load_start),
        .i_shift      (shift_en),
        .i_byte       (i_load_byte),
        .o_word       (asm_word),
        .o_word_valid (asm_word_valid)
    );

    assign last_word = (asm_word == HALT_INSTR) ||
                       ((wr_ptr + 1'b1) == (NB_ADDR + 1)'(N_WORDS));

    always_comb begin
        next_state = state;
        if (i_load_start) begin
            next_state = LD_LOADING;
        end else begin
            case (state)
                LD_IDLE:    next_state = LD_IDLE;
                LD_LOADING: if (asm_word_valid && last_word) next_state = LD_DONE;
                LD_DONE:    next_state = LD_DONE;
                default:    next_state = LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= LD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Word-aligned fetch; addresses beyond the array read as NOP.
    assign fetch              = (state == LD_DONE) && i_enable;
    assign rd_word            = (i_pc[NB-1:NB_ADDR+2] != '0) ? NOP_INSTR
                                                             : mem[i_pc[NB_ADDR+1:2]];
    assign unused_pc_byte_sel = ^i_pc[1:0];

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            wr_ptr         <= '0;
            o_load_done    <= 1'b0;
            o_instruction  <= '0;
            o_halt_fetched <= 1'b0;
        end else begin
            if (i_load_start) begin
                wr_ptr <= '0;
            end else if (asm_word_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            o_load_done <= (next_state == LD_DONE);

            if (fetch) begin
                o_instruction <= rd_word;
            end

            if (i_load_start) begin
                o_halt_fetched <= 1'b0;
            end else if (fetch && (rd_word == HALT_INSTR)) begin
                o_halt_fetched <= 1'b1;
            end
        end
    end

    // Memory is deliberately not reset; wr_ptr never reaches N_WORDS while writing.
    always_ff @(posedge i_clock) begin
        if (asm_word_valid) begin
            mem[wr_ptr[NB_ADDR-1:0]] <= asm_word;
        end
    end

    assign o_load_count = wr_ptr;
    assign o_dbg_state  = state;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: loads programs, fetches them back
// and compares against expected words queued when each fetch is issued.
module tb_instruction_memory_loader;
    import instruction_memory_loader_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [31:0]  pc;
    logic         load_start;
    logic         load_valid;
    logic [7:0]   load_byte;
    logic [31:0]  instruction;
    logic         load_done;
    logic [6:0]   load_count;
    logic         halt_fetched;
    logic [1:0]   dbg_state;

    logic [31:0]  exp_q[$];
    logic [31:0]  model [64];
    int           n_checks = 0;
    int           n_fail   = 0;

    instruction_memory_loader dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_pc           (pc),
        .i_load_start   (load_start),
        .i_load_valid   (load_valid),
        .i_load_byte    (load_byte),
        .o_instruction  (instruction),
        .o_load_done    (load_done),
        .o_load_count   (load_count),
        .o_halt_fetched (halt_fetched),
        .o_dbg_state    (dbg_state)
    );

    // clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8]);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] want;
        enable = 1'b1;
        pc     = addr;
        exp_q.push_back(exp);
        tick();
        enable = 1'b0;
        want   = exp_q.pop_front();
        check(tag, instruction, want);
    endtask

    // directed sequence
    initial begin
        logic [31:0] w;

        reset      = 1'b0;
        enable     = 1'b0;
        pc         = '0;
        load_start = 1'b0;
        load_valid = 1'b1;
        load_byte  = 8'hFF;

        // Reset with valid bytes present
        tick();
        tick();
        check("rst_instr", instruction, 32'h0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_halt", 32'(halt_fetched), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(LD_IDLE));
        reset = 1'b1;
        tick();
        tick();
        check("idle_ignore_count", 32'(load_count), 32'd0);
        check("idle_ignore_state", 32'(dbg_state), 32'(LD_IDLE));
        load_valid = 1'b0;

        // Three-word program ending in HALT
        pulse_start();
        check("ld_state", 32'(dbg_state), 32'(LD_LOADING));
        send_word(32'h0000_0001);
        send_word(32'h2008_0005);
        check("ld_count2", 32'(load_count), 32'd2);
        check("ld_done_early", 32'(load_done), 32'd0);
        send_word(HALT_INSTR);
        check("ld_count3", 32'(load_count), 32'd3);
        check("ld_done", 32'(load_done), 32'd1);
        check("ld_state_done", 32'(dbg_state), 32'(LD_DONE));

        // Fetch side
        fetch("rd_pc4", 32'd4, 32'h2008_0005);
        fetch("rd_pc5", 32'd5, 32'h2008_0005);
        fetch("rd_pc0", 32'd0, 32'h0000_0001);
        fetch("rd_pc3", 32'd3, 32'h0000_0001);
        check("halt_before", 32'(halt_fetched), 32'd0);
        fetch("rd_pc8", 32'd8, HALT_INSTR);
        check("halt_set", 32'(halt_fetched), 32'd1);
        fetch("rd_pc400", 32'h400, NOP_INSTR);
        check("halt_sticky", 32'(halt_fetched), 32'd1);
        pc = 32'd4;
        tick();
        check("rd_hold_no_enable", instruction, 32'h0);

        // Restart from DONE with a coincident byte
        load_start = 1'b1;
        load_valid = 1'b1;
        load_byte  = 8'h12;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        check("rs_done", 32'(load_done), 32'd0);
        check("rs_count", 32'(load_count), 32'd0);
        check("rs_halt", 32'(halt_fetched), 32'd0);
        check("rs_state", 32'(dbg_state), 32'(LD_LOADING));
        enable = 1'b1;
        pc     = 32'd4;
        tick();
        check("rs_hold_loading", instruction, 32'h0);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        check("rs_hold_loading2", instruction, 32'h0);
        check("rs_count1", 32'(load_count), 32'd1);
        enable = 1'b0;
        send_word(HALT_INSTR);
        check("rs_done2", 32'(load_done), 32'd1);
        fetch("rs_rd_pc0", 32'd0, 32'h1234_5678);
        fetch("rs_rd_pc4", 32'd4, HALT_INSTR);

        // Reset in the middle of a load
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h11 + i));
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_state", 32'(dbg_state), 32'(LD_IDLE));
        check("mid_rst_count", 32'(load_count), 32'd0);
        pulse_start();
        send_word(32'hAABB_CCDD);
        check("mid_rst_count1", 32'(load_count), 32'd1);
        check("mid_rst_not_done", 32'(load_done), 32'd0);
        send_word(HALT_INSTR);
        fetch("mid_rst_rd_pc0", 32'd0, 32'hAABB_CCDD);

        // Fill memory without HALT
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            w        = {8'($urandom_range(0, 254)), 24'($urandom)};
            model[i] = w;
            send_word(w);
            if (i == 62) begin
                check("full_count63", 32'(load_count), 32'd63);
                check("full_not_done", 32'(load_done), 32'd0);
            end
        end
        check("full_count64", 32'(load_count), 32'd64);
        check("full_done", 32'(load_done), 32'd1);
        check("full_state", 32'(dbg_state), 32'(LD_DONE));
        send_word(32'hDEAD_BEEF);
        check("full_extra_count", 32'(load_count), 32'd64);
        fetch("full_rd_w0", 32'd0, model[0]);
        fetch("full_rd_w17", 32'd68, model[17]);
        fetch("full_rd_w63", 32'd252, model[63]);
        fetch("full_rd_oob", 32'h100, NOP_INSTR);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
